// File: rtl/tl_mem_responder.sv
// TileLink-UL style line-wide memory slave: accepts Get/PutFull/PutPartial on A, answers in order on D after LATENCY.
// Optional TL_RESP_BACKPRESSURE_EN throttles a_ready with a 16-bit LFSR.
module tl_mem_responder #(
    parameter int          DATA_WIDTH   = 128,
    parameter int          SOURCE_WIDTH = 15,
    parameter logic [31:0] BASE_ADDR    = 32'h8000_0000,
    parameter int          DEPTH        = 1024,
    parameter int          LATENCY      = 4,
    parameter int          QUEUE_DEPTH  = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    a_valid,
    output logic                    a_ready,
    input  logic [2:0]              a_opcode,
    input  logic [3:0]              a_size,
    input  logic [SOURCE_WIDTH-1:0] a_source,
    input  logic [31:0]             a_address,
    input  logic [DATA_WIDTH/8-1:0] a_mask,
    input  logic [DATA_WIDTH-1:0]   a_data,
    output logic                    d_valid,
    input  logic                    d_ready,
    output logic [2:0]              d_opcode,
    output logic [3:0]              d_size,
    output logic [SOURCE_WIDTH-1:0] d_source,
    output logic                    d_denied,
    output logic [DATA_WIDTH-1:0]   d_data
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
    localparam int TMR_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    localparam logic [32:0]      MEM_BYTES      = 33'(DEPTH) * 33'(BYTES);
    localparam logic [2:0]       OP_PUT_FULL    = 3'd0;
    localparam logic [2:0]       OP_PUT_PARTIAL = 3'd1;
    localparam logic [2:0]       OP_GET         = 3'd4;
    localparam logic [2:0]       OP_ACK         = 3'd0;
    localparam logic [2:0]       OP_ACK_DATA    = 3'd1;
    localparam logic [3:0]       SIZE_LINE      = 4'(OFF_W);
    localparam logic [TMR_W-1:0] TMR_INIT       = TMR_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_FULL       = CNT_W'(QUEUE_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST       = PTR_W'(QUEUE_DEPTH - 1);

    // Line storage; contents survive reset.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Response queue payload, indexed by pointer; validity is tracked by count_q.
    logic [2:0]              q_opcode_q [QUEUE_DEPTH];
    logic [3:0]              q_size_q   [QUEUE_DEPTH];
    logic [SOURCE_WIDTH-1:0] q_source_q [QUEUE_DEPTH];
    logic                    q_denied_q [QUEUE_DEPTH];
    logic [DATA_WIDTH-1:0]   q_data_q   [QUEUE_DEPTH];
    logic [QUEUE_DEPTH-1:0]  timer_zero;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [31:0]      offset;
    logic             op_ok;
    logic             denied;
    logic [IDX_W-1:0] line_idx;
    logic [BYTES-1:0] wr_be;
    logic [2:0]       rsp_opcode;
    logic             push;
    logic             pop;
    logic             do_write;
    logic             do_read;
    logic             throttle;

    always_comb begin
        offset     = a_address - BASE_ADDR;
        op_ok      = (a_opcode == OP_PUT_FULL) || (a_opcode == OP_PUT_PARTIAL) || (a_opcode == OP_GET);
        denied     = !op_ok
                   || (a_size != SIZE_LINE)
                   || (a_address[OFF_W-1:0] != '0)
                   || ({1'b0, offset} >= MEM_BYTES);
        line_idx   = offset[OFF_W +: IDX_W];
        wr_be      = (a_opcode == OP_PUT_FULL) ? '1 : a_mask;
        rsp_opcode = (a_opcode == OP_GET) ? OP_ACK_DATA : OP_ACK;
    end

`ifdef TL_RESP_BACKPRESSURE_EN
    logic [15:0] lfsr_q, lfsr_d;

    // Taps 16,14,13,11 in right-shift form: feedback from bits 0,2,3,5 enters at bit 15.
    always_comb begin
        lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    always_comb begin
        throttle = (lfsr_q[1:0] == 2'b00);
    end
`else
    always_comb begin
        throttle = 1'b0;
    end
`endif

    always_comb begin
        a_ready  = ~reset & (count_q < CNT_FULL) & ~throttle;
        d_valid  = ~reset & (count_q != '0) & timer_zero[rd_ptr_q];
        push     = a_valid & a_ready;
        pop      = d_valid & d_ready;
        do_write = push & ~denied & (a_opcode != OP_GET);
        do_read  = push & ~denied & (a_opcode == OP_GET);
    end

    // Outputs are forced to zero whenever nothing is being presented.
    always_comb begin
        d_opcode = '0;
        d_size   = '0;
        d_source = '0;
        d_denied = 1'b0;
        d_data   = '0;
        if (d_valid) begin
            d_opcode = q_opcode_q[rd_ptr_q];
            d_size   = q_size_q[rd_ptr_q];
            d_source = q_source_q[rd_ptr_q];
            d_denied = q_denied_q[rd_ptr_q];
            d_data   = q_data_q[rd_ptr_q];
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_write) begin
            for (int b = 0; b < BYTES; b++) begin
                if (wr_be[b]) begin
                    mem[line_idx][b*8 +: 8] <= a_data[b*8 +: 8];
                end
            end
        end
    end

    // Get data is sampled at acceptance, so later Puts cannot disturb a queued response.
    always_ff @(posedge clock) begin
        if (push) begin
            q_opcode_q[wr_ptr_q] <= rsp_opcode;
            q_size_q[wr_ptr_q]   <= a_size;
            q_source_q[wr_ptr_q] <= a_source;
            q_denied_q[wr_ptr_q] <= denied;
            q_data_q[wr_ptr_q]   <= do_read ? mem[line_idx] : '0;
        end
    end

    for (genvar gi = 0; gi < QUEUE_DEPTH; gi++) begin : g_timer
        logic [TMR_W-1:0] timer_q;

        always_ff @(posedge clock) begin
            if (reset) begin
                timer_q <= '0;
            end else if (push && (wr_ptr_q == PTR_W'(gi))) begin
                timer_q <= TMR_INIT;
            end else if (timer_q != '0) begin
                timer_q <= timer_q - TMR_W'(1);
            end
        end

        assign timer_zero[gi] = (timer_q == '0);
    end

endmodule

// File: tb/tb_tl_mem_responder.sv
// Bench for tl_mem_responder: directed scenarios then random traffic against a queue/array reference model.
// Build with TL_RESP_BACKPRESSURE_EN to also track the a_ready throttle pattern.
module tb_tl_mem_responder;
    localparam int          LATENCY = 4;
    localparam int          QD      = 4;
    localparam int          DEPTH   = 1024;
    localparam logic [31:0] BASE    = 32'h8000_0000;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         a_valid = 1'b0;
    logic         a_ready;
    logic [2:0]   a_opcode = '0;
    logic [3:0]   a_size = '0;
    logic [14:0]  a_source = '0;
    logic [31:0]  a_address = '0;
    logic [15:0]  a_mask = '0;
    logic [127:0] a_data = '0;
    logic         d_valid;
    logic         d_ready = 1'b0;
    logic [2:0]   d_opcode;
    logic [3:0]   d_size;
    logic [14:0]  d_source;
    logic         d_denied;
    logic [127:0] d_data;

    always #5 clock = ~clock;

    tl_mem_responder dut (
        .clock     (clock),
        .reset     (reset),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_opcode  (a_opcode),
        .a_size    (a_size),
        .a_source  (a_source),
        .a_address (a_address),
        .a_mask    (a_mask),
        .a_data    (a_data),
        .d_valid   (d_valid),
        .d_ready   (d_ready),
        .d_opcode  (d_opcode),
        .d_size    (d_size),
        .d_source  (d_source),
        .d_denied  (d_denied),
        .d_data    (d_data)
    );

    typedef struct {
        logic [2:0]   op;
        logic [3:0]   size;
        logic [14:0]  src;
        logic         den;
        logic [127:0] data;
        int           due;
    } rsp_t;

    rsp_t         exp_q[$];
    logic [127:0] mem_m [int];
    int           cyc = 0;
    int           n_checks = 0;
    int           n_fail = 0;
    bit           chk_en = 1'b0;
    bit           a_hs = 1'b0;
    bit           d_hs = 1'b0;
`ifdef TL_RESP_BACKPRESSURE_EN
    logic [15:0]  lfsr_m = 16'hACE1;
`endif

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    // Reference behaviour of one accepted request: decode, apply to memory, queue the response.
    task automatic model_accept();
        rsp_t         r;
        logic [31:0]  off;
        logic [127:0] cur;
        int           line;
        off    = a_address - BASE;
        line   = int'(off >> 4);
        r.src  = a_source;
        r.size = a_size;
        r.data = '0;
        r.due  = cyc + LATENCY;
        r.op   = (a_opcode == 3'd4) ? 3'd1 : 3'd0;
        r.den  = !(a_opcode inside {3'd0, 3'd1, 3'd4}) || (a_size != 4'd4)
               || (a_address[3:0] != 4'h0) || (off >= 32'(DEPTH * 16));
        if (!r.den) begin
            cur = mem_m.exists(line) ? mem_m[line] : 'x;
            if (a_opcode == 3'd4) begin
                r.data = cur;
            end else begin
                for (int b = 0; b < 16; b++) begin
                    if (a_opcode == 3'd0 || a_mask[b]) cur[b*8 +: 8] = a_data[b*8 +: 8];
                end
                mem_m[line] = cur;
            end
        end
        exp_q.push_back(r);
    endtask

    // Called just after a negedge with inputs driven; compares, advances the model over one posedge.
    task automatic tick();
        logic exp_ar;
        logic exp_dv;
        #1;
        exp_ar = !reset && (exp_q.size() < QD);
`ifdef TL_RESP_BACKPRESSURE_EN
        exp_ar = exp_ar && (lfsr_m[1:0] != 2'b00);
`endif
        exp_dv = 1'b0;
        if (!reset && exp_q.size() != 0) exp_dv = (cyc >= exp_q[0].due);
        if (chk_en) begin
            check_eq("a_ready", 128'(a_ready), 128'(exp_ar));
            check_eq("d_valid", 128'(d_valid), 128'(exp_dv));
            if (exp_dv) begin
                check_eq("d_opcode", 128'(d_opcode), 128'(exp_q[0].op));
                check_eq("d_size", 128'(d_size), 128'(exp_q[0].size));
                check_eq("d_source", 128'(d_source), 128'(exp_q[0].src));
                check_eq("d_denied", 128'(d_denied), 128'(exp_q[0].den));
                check_eq("d_data", d_data, exp_q[0].data);
            end else if (reset) begin
                check_eq("rst_d_opcode", 128'(d_opcode), 128'(0));
                check_eq("rst_d_source", 128'(d_source), 128'(0));
                check_eq("rst_d_data", d_data, 128'(0));
            end
        end
        a_hs = a_valid && exp_ar;
        d_hs = d_ready && exp_dv;
        if (d_hs) begin
            $display("rsp cyc=%0d src=%h op=%0d den=%0d data=%h",
                     cyc, exp_q[0].src, exp_q[0].op, exp_q[0].den, exp_q[0].data);
            void'(exp_q.pop_front());
        end
        if (a_hs) model_accept();
        @(posedge clock);
        cyc++;
        if (reset) exp_q.delete();
`ifdef TL_RESP_BACKPRESSURE_EN
        if (reset) lfsr_m = 16'hACE1;
        else lfsr_m = {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5], lfsr_m[15:1]};
`endif
        @(negedge clock);
    endtask

    task automatic drive_a(input logic [2:0] op, input logic [3:0] sz, input logic [14:0] src,
                           input logic [31:0] addr, input logic [15:0] mask, input logic [127:0] data);
        a_valid   = 1'b1;
        a_opcode  = op;
        a_size    = sz;
        a_source  = src;
        a_address = addr;
        a_mask    = mask;
        a_data    = data;
    endtask

    task automatic wait_accept();
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!a_hs && n < 100);
        check_eq("accept_wait", 128'(a_hs), 128'(1));
        a_valid = 1'b0;
    endtask

    task automatic send(input logic [2:0] op, input logic [3:0] sz, input logic [14:0] src,
                        input logic [31:0] addr, input logic [15:0] mask, input logic [127:0] data);
        drive_a(op, sz, src, addr, mask, data);
        wait_accept();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        check_eq("drain_wait", 128'(exp_q.size()), 128'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [127:0] d0;
        logic [2:0]   op;
        logic [3:0]   sz;
        logic [31:0]  addr;
        int           r;
        d0 = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;

        repeat (2) @(posedge clock);
        @(negedge clock);
        chk_en = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        d_ready = 1'b1;

        // PutFull then Get of line 0.
        send(3'd0, 4'd4, 15'h11, BASE, 16'h0000, d0);
        send(3'd4, 4'd4, 15'h12, BASE, 16'h0000, '0);
        drain();

        // PutPartial of the low word only.
        send(3'd1, 4'd4, 15'h13, BASE, 16'h000F, 128'hDEADBEEF);
        send(3'd4, 4'd4, 15'h14, BASE, 16'h0000, '0);
        drain();

        // Denied requests, including a denied Put that must not touch line 0.
        send(3'd4, 4'd4, 15'h15, 32'h7FFF_FFF0, 16'h0, '0);
        send(3'd4, 4'd2, 15'h16, BASE, 16'h0, '0);
        send(3'd3, 4'd4, 15'h17, BASE, 16'hFFFF, '1);
        send(3'd4, 4'd4, 15'h18, BASE + 32'd16384, 16'h0, '0);
        send(3'd0, 4'd4, 15'h19, BASE + 32'd8, 16'h0, '1);
        send(3'd4, 4'd4, 15'h1A, BASE, 16'h0, '0);
        drain();

        // Fill lines 1..7 so every later Get targets known data.
        for (int i = 1; i < 8; i++) begin
            send(3'd0, 4'd4, 15'(16'h100 + i), BASE + 32'(i * 16), 16'h0,
                 {$urandom, $urandom, $urandom, $urandom});
        end
        drain();

        // Queue full with D stalled, then release.
        d_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(3'd4, 4'd4, 15'(16'h20 + i), BASE + 32'(i * 16), 16'h0, '0);
        end
        drive_a(3'd4, 4'd4, 15'h24, BASE + 32'd64, 16'h0, '0);
        repeat (3) tick();
        d_ready = 1'b1;
        wait_accept();
        drain();

        // A later Put must not change the data of a Get already queued.
        send(3'd0, 4'd4, 15'h30, BASE + 32'd80, 16'h0, 128'hAAAA_0000_1111_2222_3333_4444_5555_6666);
        send(3'd4, 4'd4, 15'h31, BASE + 32'd80, 16'h0, '0);
        send(3'd0, 4'd4, 15'h32, BASE + 32'd80, 16'h0, 128'hBBBB_9999_8888_7777_6666_5555_4444_3333);
        drain();
        send(3'd4, 4'd4, 15'h33, BASE + 32'd80, 16'h0, '0);
        drain();

        // Reset with responses pending; the accepted Put must persist.
        d_ready = 1'b0;
        send(3'd0, 4'd4, 15'h40, BASE + 32'd96, 16'h0, 128'hC0FFEE00_12345678_9ABCDEF0_0F0F0F0F);
        send(3'd4, 4'd4, 15'h41, BASE, 16'h0, '0);
        send(3'd4, 4'd4, 15'h42, BASE + 32'd16, 16'h0, '0);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        d_ready = 1'b1;
        repeat (6) tick();
        send(3'd4, 4'd4, 15'h43, BASE + 32'd96, 16'h0, '0);
        drain();

        // Random traffic over lines 0..7 with occasional illegal requests.
        for (int i = 0; i < 600; i++) begin
            if (!a_valid && ($urandom_range(0, 2) != 0)) begin
                r = $urandom_range(0, 9);
                op = (r < 4) ? 3'd4 : (r < 6) ? 3'd0 : (r < 8) ? 3'd1 : 3'($urandom_range(2, 7));
                sz = ($urandom_range(0, 15) == 0) ? 4'd2 : 4'd4;
                addr = BASE + 32'($urandom_range(0, 7) * 16);
                if (r == 9) addr = ($urandom_range(0, 1) == 0) ? BASE - 32'd16 : addr + 32'd4;
                drive_a(op, sz, 15'($urandom), addr, 16'($urandom),
                        {$urandom, $urandom, $urandom, $urandom});
            end
            d_ready = ($urandom_range(0, 3) != 0);
            tick();
            if (a_hs) a_valid = 1'b0;
        end
        a_valid = 1'b0;
        d_ready = 1'b1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
